lsu: RTL

//  Load/store unit that services the memory requests issued by the execution stage
//  (mem_load_* / mem_store_*) and drives them onto a single-outstanding data bus.

---
 rtl/lsu_if.sv | 21 ++
 rtl/lsu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - single-outstanding data bus between the LSU and memory
interface lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit with lane steering and load extension; optional LSU_MISALIGN_TRAP_EN
module lsu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_load_en,
    input  logic [XLEN-1:0]   mem_load_addr,
    input  logic [REG_AW-1:0] mem_load_regs_addr,
    input  logic [2:0]        mem_load_funct3,
    input  logic              mem_store_en,
    input  logic [XLEN-1:0]   mem_store_addr,
    input  logic [XLEN-1:0]   mem_store_data,
    input  logic [2:0]        mem_store_funct3,
    lsu_if.master             bus,
    output logic              regs_write_en,
    output logic [REG_AW-1:0] regs_write_addr,
    output logic [XLEN-1:0]   regs_write_data,
    output logic              pause_signal,
    output logic              unpause_signal,
    output logic              misalign_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [REG_AW-1:0] ld_rd;
    logic [2:0]        ld_f3;
    logic [1:0]        ld_off;
    logic              is_load;

    // Byte enables for a store; unknown funct3 behaves as a full word.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  store_strb = 4'b0001 << off;
            3'b001:  store_strb = 4'b0011 << {off[1], 1'b0};
            default: store_strb = 4'hF;
        endcase
    endfunction

    // Replicate the significant store bytes across every lane so any offset finds them.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  store_wdata = {4{d[7:0]}};
            3'b001:  store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] b;
        logic [31:0] h;
        b = rdata >> (8 * off);
        h = rdata >> (16 * off[1]);
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b[7:0]};
            3'b001:  load_extract = {{16{h[15]}}, h[15:0]};
            3'b100:  load_extract = {24'd0, b[7:0]};
            3'b101:  load_extract = {16'd0, h[15:0]};
            default: load_extract = rdata;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // Halves need an even address, words (including unknown funct3) a 4-byte-aligned one.
    function automatic logic misaligned(input logic ld, input logic [2:0] f3, input logic [1:0] off);
        logic is_byte;
        logic is_half;
        is_byte = ld ? (f3 == 3'b000 || f3 == 3'b100) : (f3 == 3'b000);
        is_half = ld ? (f3 == 3'b001 || f3 == 3'b101) : (f3 == 3'b001);
        if (is_byte)      misaligned = 1'b0;
        else if (is_half) misaligned = off[0];
        else              misaligned = (off != 2'b00);
    endfunction
`else
    assign misalign_err = 1'b0;
`endif

    // Request sequencing with all bus and write-back outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            ld_rd           <= '0;
            ld_f3           <= '0;
            ld_off          <= '0;
            is_load         <= 1'b0;
            bus.bus_req     <= 1'b0;
            bus.bus_we      <= 1'b0;
            bus.bus_addr    <= '0;
            bus.bus_wdata   <= '0;
            bus.bus_wstrb   <= '0;
            regs_write_en   <= 1'b0;
            regs_write_addr <= '0;
            regs_write_data <= '0;
            pause_signal    <= 1'b0;
            unpause_signal  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_load_en) begin
                        ld_rd        <= mem_load_regs_addr;
                        ld_f3        <= mem_load_funct3;
                        ld_off       <= mem_load_addr[1:0];
                        is_load      <= 1'b1;
                        pause_signal <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned(1'b1, mem_load_funct3, mem_load_addr[1:0])) begin
                            misalign_err   <= 1'b1;
                            unpause_signal <= 1'b1;
                            state          <= S_DONE;
                        end else
`endif
                        begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= 1'b0;
                            bus.bus_addr  <= {mem_load_addr[31:2], 2'b00};
                            bus.bus_wdata <= '0;
                            bus.bus_wstrb <= '0;
                            state         <= S_REQ;
                        end
                    end else if (mem_store_en) begin
                        is_load      <= 1'b0;
                        pause_signal <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned(1'b0, mem_store_funct3, mem_store_addr[1:0])) begin
                            misalign_err   <= 1'b1;
                            unpause_signal <= 1'b1;
                            state          <= S_DONE;
                        end else
`endif
                        begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= 1'b1;
                            bus.bus_addr  <= {mem_store_addr[31:2], 2'b00};
                            bus.bus_wdata <= store_wdata(mem_store_funct3, mem_store_data);
                            bus.bus_wstrb <= store_strb(mem_store_funct3, mem_store_addr[1:0]);
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.bus_gnt) begin
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        bus.bus_wdata <= '0;
                        bus.bus_wstrb <= '0;
                        if (!is_load) begin
                            unpause_signal <= 1'b1;
                            state          <= S_DONE;
                        end else if (bus.bus_rvalid) begin
                            regs_write_en   <= (ld_rd != '0);
                            regs_write_addr <= ld_rd;
                            regs_write_data <= load_extract(ld_f3, ld_off, bus.bus_rdata);
                            unpause_signal  <= 1'b1;
                            state           <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.bus_rvalid) begin
                        regs_write_en   <= (ld_rd != '0);
                        regs_write_addr <= ld_rd;
                        regs_write_data <= load_extract(ld_f3, ld_off, bus.bus_rdata);
                        unpause_signal  <= 1'b1;
                        state           <= S_DONE;
                    end
                end
                default: begin
                    regs_write_en  <= 1'b0;
                    unpause_signal <= 1'b0;
                    pause_signal   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_err   <= 1'b0;
`endif
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule
